// File: rtl/mctp_axi_wr_assembler.sv
// mctp_axi_wr_assembler
//   AXI4 write slave terminating the MCTP-over-PCIe-VDM write stream. Each
//   burst is one packet; beat 0 carries the TLP header with {typ, sn, tag} in
//   WDATA[127:120]. Packets are checked for S/M/L/SG ordering, sequence
//   continuity and tag consistency, then forwarded as a framed 256-bit
//   message stream. Offending packets are dropped and answered with SLVERR.
//
//   Ports:
//     i_clk, i_reset            clock, async active-high reset
//     I_AW* / O_AWREADY         write address channel (AWADDR not decoded)
//     I_W*  / O_WREADY          write data channel (WSTRB ignored)
//     O_B*  / I_BREADY          write response channel
//     o_msg_*  / i_msg_ready    message stream (err only meaningful with eof)
//     o_msg_cnt, o_err_cnt      stats counters, present with MCTP_ASM_STATS_EN
//
//   Build option: define MCTP_ASM_STATS_EN for the saturating counters.
module mctp_axi_wr_assembler
`ifdef MCTP_ASM_STATS_EN
  #(parameter int STATS_W = 16)
`endif
(
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [6:0]   I_AWID,
  input  logic [63:0]  I_AWADDR,
  input  logic [7:0]   I_AWLEN,
  input  logic         I_AWVALID,
  output logic         O_AWREADY,
  input  logic [255:0] I_WDATA,
  input  logic [31:0]  I_WSTRB,
  input  logic         I_WLAST,
  input  logic         I_WVALID,
  output logic         O_WREADY,
  output logic [6:0]   O_BID,
  output logic [1:0]   O_BRESP,
  output logic         O_BVALID,
  input  logic         I_BREADY,
  output logic [255:0] o_msg_data,
  output logic         o_msg_sof,
  output logic         o_msg_eof,
  output logic         o_msg_err,
  output logic [3:0]   o_msg_tag,
  output logic         o_msg_valid,
  input  logic         i_msg_ready
`ifdef MCTP_ASM_STATS_EN
  ,
  output logic [STATS_W-1:0] o_msg_cnt,
  output logic [STATS_W-1:0] o_err_cnt
`endif
);

  typedef enum logic [1:0] {A_INIT, A_IDLE, A_DATA, A_RESP} a_st_t;
  typedef enum logic       {M_IDLE, M_ASM} m_st_t;

  localparam logic [1:0] T_M = 2'b00, T_L = 2'b01, T_S = 2'b10, T_SG = 2'b11;

  a_st_t       a_state, a_next;
  m_st_t       m_state, m_next;
  logic [7:0]  awlen_q, beat_q;
  logic        drop_q, perr_q, eofl_q;   // per-packet: drop rest / SLVERR / eof on last beat
  logic [1:0]  exp_sn, exp_sn_n;
  logic [3:0]  cur_tag, cur_tag_n;
  logic        wready, w_acc, last, wl_err, hdr_ok;
  logic        b_fwd, b_sof, b_eof, b_err, b_drop, b_perr, b_eofl;
  logic [1:0]  h_typ, h_sn;
  logic [3:0]  h_tag;
  logic        unused_in;

  assign unused_in = ^{I_AWADDR, I_WSTRB};

  assign h_typ  = I_WDATA[127:126];
  assign h_sn   = I_WDATA[125:124];
  assign h_tag  = I_WDATA[123:120];
  assign hdr_ok = (h_typ == T_M || h_typ == T_L) && h_tag == cur_tag && h_sn == exp_sn;

  // Beat 0 always waits for output space (its fate is unknown yet); later
  // beats of a dropped packet are swallowed every cycle.
  assign wready    = (a_state == A_DATA) &&
                     ((drop_q && beat_q != 8'd0) || !o_msg_valid || i_msg_ready);
  assign O_WREADY  = wready;
  assign w_acc     = wready & I_WVALID;
  assign last      = (beat_q == awlen_q);
  assign wl_err    = (I_WLAST != last);
  assign O_AWREADY = (a_state == A_IDLE);
  assign O_BVALID  = (a_state == A_RESP);

  // ---------------- AXI FSM ----------------
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) a_state <= A_INIT;
    else         a_state <= a_next;

  always_comb begin
    a_next = a_state;
    case (a_state)
      A_INIT:  a_next = A_IDLE;
      A_IDLE:  if (I_AWVALID)     a_next = A_DATA;
      A_DATA:  if (w_acc && last) a_next = A_RESP;
      A_RESP:  if (I_BREADY)      a_next = A_IDLE;
      default: a_next = A_INIT;
    endcase
  end

  // ---------------- assembly FSM ----------------
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      m_state <= M_IDLE;
      exp_sn  <= '0;
      cur_tag <= '0;
    end else begin
      m_state <= m_next;
      exp_sn  <= exp_sn_n;
      cur_tag <= cur_tag_n;
    end

  // Per-beat disposition of the beat being accepted.
  always_comb begin
    b_fwd  = 1'b0;
    b_sof  = 1'b0;
    b_eof  = 1'b0;
    b_err  = 1'b0;
    b_drop = drop_q;
    b_perr = perr_q;
    b_eofl = eofl_q;
    if (w_acc) begin
      if (beat_q == 8'd0) begin
        b_drop = 1'b0;
        b_perr = 1'b0;
        b_eofl = 1'b0;
        if (m_state == M_IDLE) begin
          if (h_typ == T_SG)     begin b_fwd = 1'b1; b_sof = 1'b1; b_eofl = 1'b1; end
          else if (h_typ == T_S) begin b_fwd = 1'b1; b_sof = 1'b1; end
          else                   begin b_drop = 1'b1; b_perr = 1'b1; end
        end else if (hdr_ok) begin
          b_fwd  = 1'b1;
          b_eofl = (h_typ == T_L);
        end else begin
          // broken sequence: close the open message on this header beat
          b_fwd = 1'b1; b_eof = 1'b1; b_err = 1'b1; b_drop = 1'b1; b_perr = 1'b1;
        end
      end else begin
        b_fwd = !drop_q;
      end
      if (b_fwd && last && b_eofl) b_eof = 1'b1;
      // WLAST disagreeing with AWLEN: the count still ends the burst, but the
      // packet is bad and any open message is cut here.
      if (wl_err) begin
        b_perr = 1'b1;
        b_drop = 1'b1;
        if (b_fwd) begin b_eof = 1'b1; b_err = 1'b1; end
      end
    end
  end

  always_comb begin
    m_next    = m_state;
    exp_sn_n  = exp_sn;
    cur_tag_n = cur_tag;
    if (w_acc) begin
      if (beat_q == 8'd0 && m_state == M_IDLE && h_typ == T_S) begin
        m_next    = M_ASM;
        cur_tag_n = h_tag;
        exp_sn_n  = h_sn + 2'd1;
      end
      if (beat_q == 8'd0 && m_state == M_ASM && hdr_ok) exp_sn_n = exp_sn + 2'd1;
      if (b_eof || wl_err) m_next = M_IDLE;
    end
  end

  // ---------------- burst tracking, response, output register ----------------
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      awlen_q     <= '0;
      beat_q      <= '0;
      drop_q      <= 1'b0;
      perr_q      <= 1'b0;
      eofl_q      <= 1'b0;
      O_BID       <= '0;
      O_BRESP     <= '0;
      o_msg_data  <= '0;
      o_msg_sof   <= 1'b0;
      o_msg_eof   <= 1'b0;
      o_msg_err   <= 1'b0;
      o_msg_tag   <= '0;
      o_msg_valid <= 1'b0;
    end else begin
      if (O_AWREADY && I_AWVALID) begin
        O_BID   <= I_AWID;
        awlen_q <= I_AWLEN;
        beat_q  <= '0;
      end
      if (w_acc) begin
        beat_q <= beat_q + 8'd1;
        drop_q <= b_drop;
        perr_q <= b_perr;
        eofl_q <= b_eofl;
        if (last) O_BRESP <= b_perr ? 2'b10 : 2'b00;
      end
      if (b_fwd) begin
        o_msg_data  <= I_WDATA;
        o_msg_sof   <= b_sof;
        o_msg_eof   <= b_eof;
        o_msg_err   <= b_err;
        o_msg_valid <= 1'b1;
        if (b_sof) o_msg_tag <= h_tag;
      end else if (i_msg_ready) begin
        o_msg_valid <= 1'b0;
      end
    end

`ifdef MCTP_ASM_STATS_EN
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      o_msg_cnt <= '0;
      o_err_cnt <= '0;
    end else begin
      if (b_fwd && b_eof && !b_err && o_msg_cnt != '1) o_msg_cnt <= o_msg_cnt + STATS_W'(1);
      if (w_acc && last && b_perr && o_err_cnt != '1)  o_err_cnt <= o_err_cnt + STATS_W'(1);
    end
`endif

endmodule

// File: tb/tb_mctp_axi_wr_assembler.sv
// Directed bench for mctp_axi_wr_assembler: drives AXI bursts, captures the
// message stream and compares against hand-computed beats and responses.
module tb_mctp_axi_wr_assembler;

  logic         i_clk = 1'b0;
  logic         i_reset;
  logic [6:0]   I_AWID;
  logic [63:0]  I_AWADDR;
  logic [7:0]   I_AWLEN;
  logic         I_AWVALID;
  logic         O_AWREADY;
  logic [255:0] I_WDATA;
  logic [31:0]  I_WSTRB;
  logic         I_WLAST;
  logic         I_WVALID;
  logic         O_WREADY;
  logic [6:0]   O_BID;
  logic [1:0]   O_BRESP;
  logic         O_BVALID;
  logic         I_BREADY;
  logic [255:0] o_msg_data;
  logic         o_msg_sof, o_msg_eof, o_msg_err;
  logic [3:0]   o_msg_tag;
  logic         o_msg_valid;
  logic         i_msg_ready;
`ifdef MCTP_ASM_STATS_EN
  logic [15:0]  o_msg_cnt, o_err_cnt;
`endif

  mctp_axi_wr_assembler dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .I_AWID(I_AWID), .I_AWADDR(I_AWADDR), .I_AWLEN(I_AWLEN),
    .I_AWVALID(I_AWVALID), .O_AWREADY(O_AWREADY),
    .I_WDATA(I_WDATA), .I_WSTRB(I_WSTRB), .I_WLAST(I_WLAST),
    .I_WVALID(I_WVALID), .O_WREADY(O_WREADY),
    .O_BID(O_BID), .O_BRESP(O_BRESP), .O_BVALID(O_BVALID), .I_BREADY(I_BREADY),
    .o_msg_data(o_msg_data), .o_msg_sof(o_msg_sof), .o_msg_eof(o_msg_eof),
    .o_msg_err(o_msg_err), .o_msg_tag(o_msg_tag),
    .o_msg_valid(o_msg_valid), .i_msg_ready(i_msg_ready)
`ifdef MCTP_ASM_STATS_EN
    , .o_msg_cnt(o_msg_cnt), .o_err_cnt(o_err_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [255:0] d;
    logic         sof, eof, err;
    logic [3:0]   tag;
  } beat_t;

  beat_t       mq[$];
  int          total = 0, bad = 0;
  int          base;
  logic [1:0]  r;
  logic [6:0]  bid;
  logic [7:0]  h1 [4] = '{8'h8E, 8'h1E, 8'h2E, 8'h7E};

  // capture on the falling edge: a beat counts as delivered at the next rise
  always @(negedge i_clk)
    if (!i_reset && o_msg_valid && i_msg_ready)
      mq.push_back('{o_msg_data, o_msg_sof, o_msg_eof, o_msg_err, o_msg_tag});

  task automatic chk(input string t, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", t, got, exp);
    end
  endtask

  function automatic logic [255:0] mkd(input logic [7:0] pid, input logic [7:0] b,
                                       input logic [7:0] hdr);
    return {112'd0, pid, b, hdr, 120'd0};
  endfunction

  task automatic exp_beat(input string t, input int idx, input logic [255:0] d,
                          input logic sof, input logic eof, input logic err,
                          input logic [3:0] tag);
    if (idx >= mq.size()) chk($sformatf("%s%0d_missing", t, idx), 256'd0, 256'd1);
    else begin
      chk($sformatf("%s%0d_data", t, idx), mq[idx].d, d);
      chk($sformatf("%s%0d_flags", t, idx),
          {mq[idx].sof, mq[idx].eof, mq[idx].err, mq[idx].tag}, {sof, eof, err, tag});
    end
  endtask

  // One burst: nbeats < len+1 stops mid-burst and skips the response phase.
  task automatic send_pkt(input logic [6:0] id, input logic [7:0] len, input logic [7:0] hdr,
                          input int wl_at, input int nbeats, input logic [7:0] pid,
                          output logic [1:0] resp, output logic [6:0] rid);
    bit ok;
    resp = 2'b11; rid = '0;
    @(posedge i_clk); #1;
    I_AWID = id; I_AWLEN = len; I_AWADDR = {$urandom, $urandom}; I_AWVALID = 1'b1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      if (O_AWREADY) begin ok = 1; break; end
    end
    if (!ok) chk("aw_timeout", 256'd0, 256'd1);
    @(posedge i_clk); #1;
    I_AWVALID = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      I_WDATA = mkd(pid, 8'(b), hdr); I_WLAST = (b == wl_at); I_WVALID = 1'b1;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge i_clk);
        if (O_WREADY) begin ok = 1; break; end
      end
      if (!ok) chk("w_timeout", 256'd0, 256'd1);
      @(posedge i_clk); #1;
    end
    I_WVALID = 1'b0; I_WLAST = 1'b0;
    if (nbeats == int'(len) + 1) begin
      I_BREADY = 1'b1;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge i_clk);
        if (O_BVALID) begin ok = 1; break; end
      end
      if (!ok) chk("b_timeout", 256'd0, 256'd1);
      resp = O_BRESP; rid = O_BID;
      @(posedge i_clk); #1;
      I_BREADY = 1'b0;
    end
  endtask

  initial begin
    i_reset = 1'b1; I_AWID = '0; I_AWADDR = '0; I_AWLEN = '0; I_AWVALID = 1'b0;
    I_WDATA = '0; I_WSTRB = '1; I_WLAST = 1'b0; I_WVALID = 1'b0; I_BREADY = 1'b0;
    i_msg_ready = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("rst_ctrl", {O_AWREADY, O_WREADY, O_BVALID, O_BRESP, O_BID, o_msg_valid,
                     o_msg_sof, o_msg_eof, o_msg_err, o_msg_tag}, 256'd0);
    chk("rst_data", o_msg_data, 256'd0);
    @(posedge i_clk); #1 i_reset = 1'b0;
    @(negedge i_clk);
    chk("awready_pre", O_AWREADY, 256'd0);
    @(negedge i_clk);
    chk("awready_post", O_AWREADY, 256'd1);

    // S/M/M/L, tag E, sn 0..3
    base = mq.size();
    for (int p = 0; p < 4; p++) begin
      send_pkt(7'h1, 8'd3, h1[p], 3, 4, 8'(p + 1), r, bid);
      chk($sformatf("t1_bresp%0d", p), r, 256'd0);
    end
    chk("t1_bid", bid, 256'h1);
    repeat (3) @(negedge i_clk);
    chk("t1_nbeats", mq.size() - base, 256'd16);
    for (int k = 0; k < 16; k++)
      exp_beat("t1_b", base + k, mkd(8'(k / 4 + 1), 8'(k % 4), h1[k / 4]),
               k == 0, k == 15, 1'b0, 4'hE);
`ifdef MCTP_ASM_STATS_EN
    chk("t1_msg_cnt", o_msg_cnt, 256'd1);
`endif

    // SG, then S immediately, then closing L with AWLEN=0
    base = mq.size();
    send_pkt(7'h2, 8'd3, 8'hC3, 3, 4, 8'd10, r, bid);
    chk("t2_sg_bresp", r, 256'd0);
    send_pkt(7'h2, 8'd3, 8'h85, 3, 4, 8'd11, r, bid);
    chk("t2_s_bresp", r, 256'd0);
    send_pkt(7'h2, 8'd0, 8'h55, 0, 1, 8'd12, r, bid);
    chk("t2_l_bresp", r, 256'd0);
    repeat (3) @(negedge i_clk);
    chk("t2_nbeats", mq.size() - base, 256'd9);
    for (int k = 0; k < 4; k++)
      exp_beat("t2_sg", base + k, mkd(8'd10, 8'(k), 8'hC3), k == 0, k == 3, 1'b0, 4'h3);
    for (int k = 0; k < 4; k++)
      exp_beat("t2_s", base + 4 + k, mkd(8'd11, 8'(k), 8'h85), k == 0, 1'b0, 1'b0, 4'h5);
    exp_beat("t2_l", base + 8, mkd(8'd12, 8'd0, 8'h55), 1'b0, 1'b1, 1'b0, 4'h5);

    // S sn0, M sn2 (gap), L sn3 with no open message
    base = mq.size();
    send_pkt(7'h3, 8'd3, 8'h8E, 3, 4, 8'd20, r, bid);
    chk("t3_s_bresp", r, 256'd0);
    send_pkt(7'h3, 8'd3, 8'h2E, 3, 4, 8'd21, r, bid);
    chk("t3_m_bresp", r, 256'd2);
    send_pkt(7'h3, 8'd3, 8'h7E, 3, 4, 8'd22, r, bid);
    chk("t3_l_bresp", r, 256'd2);
    repeat (3) @(negedge i_clk);
    chk("t3_nbeats", mq.size() - base, 256'd5);
    for (int k = 0; k < 4; k++)
      exp_beat("t3_s", base + k, mkd(8'd20, 8'(k), 8'h8E), k == 0, 1'b0, 1'b0, 4'hE);
    exp_beat("t3_m", base + 4, mkd(8'd21, 8'd0, 8'h2E), 1'b0, 1'b1, 1'b1, 4'hE);
`ifdef MCTP_ASM_STATS_EN
    chk("t3_err_cnt", o_err_cnt, 256'd2);
`endif

    // M with no preceding S
    base = mq.size();
    send_pkt(7'h5, 8'd3, 8'h1E, 3, 4, 8'd30, r, bid);
    chk("t4_bresp", r, 256'd2);
    chk("t4_bid", bid, 256'h5);
    repeat (3) @(negedge i_clk);
    chk("t4_nbeats", mq.size() - base, 256'd0);

    // SG with WLAST on beat 1 of 4
    base = mq.size();
    send_pkt(7'h6, 8'd3, 8'hC1, 1, 4, 8'd40, r, bid);
    chk("t5_bresp", r, 256'd2);
    repeat (3) @(negedge i_clk);
    chk("t5_nbeats", mq.size() - base, 256'd2);
    exp_beat("t5_b", base,     mkd(8'd40, 8'd0, 8'hC1), 1'b1, 1'b0, 1'b0, 4'h1);
    exp_beat("t5_b", base + 1, mkd(8'd40, 8'd1, 8'hC1), 1'b0, 1'b1, 1'b1, 4'h1);

    // S tag 9 with output stalled for 5 cycles mid-packet
    base = mq.size();
    fork
      send_pkt(7'h1, 8'd7, 8'h89, 7, 8, 8'd50, r, bid);
      begin
        for (int i = 0; i < 200 && mq.size() < base + 2; i++) @(negedge i_clk);
        @(posedge i_clk); #1 i_msg_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("t6_stall_wready", O_WREADY, 256'd0);
        chk("t6_stall_valid", o_msg_valid, 256'd1);
        repeat (2) @(posedge i_clk);
        #1 i_msg_ready = 1'b1;
      end
    join
    chk("t6_bresp", r, 256'd0);
    repeat (3) @(negedge i_clk);
    chk("t6_nbeats", mq.size() - base, 256'd8);
    for (int k = 0; k < 8; k++)
      exp_beat("t6_b", base + k, mkd(8'd50, 8'(k), 8'h89), k == 0, 1'b0, 1'b0, 4'h9);

    // reset after beat 1 of an M packet, then an SG packet
    send_pkt(7'h3, 8'd3, 8'h19, 3, 2, 8'd60, r, bid);
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("t7_rst_ctrl", {O_AWREADY, O_WREADY, O_BVALID, O_BRESP, O_BID, o_msg_valid,
                        o_msg_sof, o_msg_eof, o_msg_err, o_msg_tag}, 256'd0);
    chk("t7_rst_data", o_msg_data, 256'd0);
    @(posedge i_clk); #1 i_reset = 1'b0;
    base = mq.size();
    send_pkt(7'h4, 8'd3, 8'hC7, 3, 4, 8'd70, r, bid);
    chk("t7_bresp", r, 256'd0);
    repeat (3) @(negedge i_clk);
    chk("t7_nbeats", mq.size() - base, 256'd4);
    for (int k = 0; k < 4; k++)
      exp_beat("t7_b", base + k, mkd(8'd70, 8'(k), 8'hC7), k == 0, k == 3, 1'b0, 4'h7);
`ifdef MCTP_ASM_STATS_EN
    chk("t7_msg_cnt", o_msg_cnt, 256'd1);
    chk("t7_err_cnt", o_err_cnt, 256'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mctp_axi_wr_assembler.md
# mctp_axi_wr_assembler

AXI4 write slave that terminates the MCTP-over-PCIe-VDM write stream and reassembles multi-packet MCTP messages. Each AXI write burst carries one packet: beat 0 holds the 128-bit TLP header in WDATA[127:0], and header bits [127:120] carry {pkt type, seq num, msg tag}. The block checks S/M/L/SG ordering, sequence-number continuity and tag consistency, then forwards accepted beats as a framed 256-bit message stream to the message buffer. Violating packets are dropped and answered with SLVERR.

## Interface
- STATS_W, 16: width of statistics counters (stats build only)
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- I_AWID  in  7  write ID, captured and returned on O_BID
- I_AWADDR  in  64  ignored except for capture; no decode
- I_AWLEN  in  8  beats-1
- I_AWVALID / O_AWREADY  in/out  1  address handshake
- I_WDATA  in  256  data; beat 0 [127:0] = header
- I_WSTRB  in  32  ignored (full beats only)
- I_WLAST  in  1  last-beat marker
- I_WVALID / O_WREADY  in/out  1  data handshake
- O_BID  out  7  echoed AWID
- O_BRESP  out  2  00 OKAY, 10 SLVERR
- O_BVALID / I_BREADY  out/in  1  response handshake
- o_msg_data  out  256  forwarded beat, unmodified
- o_msg_sof / o_msg_eof / o_msg_err  out  1  message framing; err is valid only with eof
- o_msg_tag  out  4  {TO, tag[2:0]} of current message
- o_msg_valid / i_msg_ready  out/in  1  stream handshake
- o_msg_cnt, o_err_cnt  out  STATS_W  stats build only

## Operation
- Header decode on beat 0:
  - typ = WDATA[127:126]: S=10, M=00, L=01, SG=11
  - sn = WDATA[125:124]
  - tag = WDATA[123:120]
- Only one write outstanding. AXI FSM states:
  - A_IDLE: AWREADY=1; on AW handshake capture AWID and AWLEN, go to A_DATA.
  - A_DATA: beat counter runs 0..AWLEN; after beat AWLEN is accepted, go to A_RESP.
  - A_RESP: BVALID=1 until BREADY; then return to A_IDLE.
- Assembly FSM states M_IDLE, M_ASM. Registers exp_sn[1:0] and cur_tag[3:0]. Evaluated on beat 0:
  - M_IDLE + SG: forward packet; sof on beat 0, eof on last beat; stay M_IDLE.
  - M_IDLE + S: forward; sof on beat 0; cur_tag=tag, exp_sn=sn+1 (mod 4); go to M_ASM.
  - M_IDLE + M/L: drop all beats, no output, SLVERR.
  - M_ASM + M/L with tag==cur_tag and sn==exp_sn: forward packet, exp_sn+=1 (wraps 3->0). L sets eof on its last beat and returns to M_IDLE.
  - M_ASM + anything else (S, SG, tag or sn mismatch): forward beat 0 only, with eof=1 and err=1; drop remaining beats; SLVERR; go to M_IDLE.
- A packet is also in error if WLAST does not match beat==AWLEN. On a WLAST mismatch:
  - the beat count (AWLEN) governs when the burst ends;
  - BRESP=SLVERR;
  - an open message is terminated with err on the current beat (eof=1, err=1);
  - the assembly FSM goes to M_IDLE.
- Output register is a single stage. WREADY = (dropping) | !o_msg_valid | i_msg_ready. Dropped beats are accepted every cycle.

## Timing
- Reset values: all outputs 0 except O_AWREADY=0. O_AWREADY rises on the first clock edge after i_reset deasserts.
- AW handshake at edge N: O_AWREADY=0 and WREADY may be 1 from edge N.
- Forwarded beat accepted at edge N: o_msg_valid=1 after edge N, held until i_msg_ready.
- Sustained throughput: 1 beat/cycle with i_msg_ready=1.
- Last W beat accepted at edge N: O_BVALID=1 after edge N. BRESP and BID are stable while BVALID is high.
- After the B handshake at edge M, O_AWREADY=1 after edge M. This gives 1 idle cycle between bursts.
- o_msg_tag updates with the sof beat and is held through eof.
- i_reset mid-burst: both FSMs go to idle, the output register is cleared, any partial message is discarded without an eof, and counters are cleared.

## Configuration
- MCTP_ASM_STATS_EN:
  - Defined: o_msg_cnt and o_err_cnt ports exist. o_msg_cnt increments on each eof with err=0. o_err_cnt increments on each SLVERR response. Both saturate at all-ones.
  - Undefined: ports and counter logic are absent; all other behaviour is identical.

## Test plan
- S/M/M/L, tag 4'hE, sn 0..3, AWLEN=3 each -> 16 output beats, sof on beat 1, eof on beat 16, err=0, o_msg_tag=E, four BRESP=00; o_msg_cnt=1.
- Single SG, AWLEN=3 -> 4 beats with sof+eof in the same message, BRESP=00; then S accepted immediately.
- S sn0 then M sn2 (tag E) -> second packet's beat 0 output with eof=1, err=1; its other 3 beats dropped; BRESP=10; a following L sn3 produces no output, BRESP=10; o_err_cnt=2.
- M sn1 with no preceding S -> zero output beats, BRESP=10, O_BID equals AWID 7'h5.
- i_msg_ready low for 5 cycles during beat 2 of an S packet -> WREADY=0 while output is full; no beat lost or duplicated; order preserved.
- i_reset asserted after beat 1 of an M packet -> all outputs 0; then SG packet -> forwarded normally with sof=1.
